lcg_stim_gen: RTL



---
 rtl/lcg_stim_pkg.sv | 39 +++
 rtl/lcg32_step.sv | 16 +
 rtl/lcg_stim_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lcg_stim_pkg.sv
// Shared types and arithmetic for the LCG stimulus generator.
//   mode_e     : vector fill policy captured at run start
//   state_e    : controller states
//   lcg_next   : one 32-bit LCG step, state*mult + inc mod 2^32
//   decode_mode: maps the raw 2-bit mode input onto mode_e (3 -> RANDOM)
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MULT_DEF = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC_DEF  = 32'h3039;

  typedef enum logic [1:0] {
    RANDOM = 2'd0,
    COUNT  = 2'd1,
    HOLD   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_e;

  // The 32-bit result width gives the mod 2^32 wrap for free.
  function automatic logic [31:0] lcg_next(input logic [31:0] s,
                                           input logic [31:0] mult = LCG_MULT_DEF,
                                           input logic [31:0] inc  = LCG_INC_DEF);
    return s * mult + inc;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return COUNT;
      2'd2:    return HOLD;
      default: return RANDOM;
    endcase
  endfunction

endpackage

// File: rtl/lcg32_step.sv
// Combinational single step of the 32-bit linear congruential generator.
//   state_i : current LCG state
//   state_o : state_i * LCG_MULT + LCG_INC (mod 2^32)
module lcg32_step
  import lcg_stim_pkg::*;
#(
  parameter logic [31:0] LCG_MULT = LCG_MULT_DEF,
  parameter logic [31:0] LCG_INC  = LCG_INC_DEF
) (
  input  logic [31:0] state_i,
  output logic [31:0] state_o
);

  assign state_o = lcg_next(state_i, LCG_MULT, LCG_INC);

endmodule

// File: rtl/lcg_stim_gen.sv
// Seeded LCG stimulus generator with a valid/ready output and a vector count.
// Each vector is assembled one 32-bit word per cycle (FILL), then held on the
// output until the consumer takes it (PRESENT). done pulses after the last
// handshake; abort returns to IDLE without done and leaves vec untouched.
//   clk, rst           : clock, synchronous active-high reset
//   start/seed/mode/num_vec : run request and its settings, captured in IDLE
//   abort              : ends any active run
//   vec/vec_valid/vec_ready/vec_idx : stimulus vector handshake and its index
//   busy               : high whenever not IDLE
//   done               : one-cycle end-of-run pulse
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int unsigned OUT_W    = 138,
  parameter logic [31:0] LCG_MULT = LCG_MULT_DEF,
  parameter logic [31:0] LCG_INC  = LCG_INC_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             abort,
  output logic [OUT_W-1:0] vec,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NWORDS = (OUT_W + 31) / 32;
  localparam int unsigned WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);

  state_e             state_q,   state_d;
  mode_e              mode_q,    mode_d;
  logic [CNT_W-1:0]   num_vec_q, num_vec_d;
  logic [31:0]        lcg_q,     lcg_d;
  logic [OUT_W-1:0]   vec_q,     vec_d;
  logic [CNT_W-1:0]   vec_idx_q, vec_idx_d;
  logic [WCNT_W-1:0]  word_q,    word_d;
  logic [31:0]        lcg_nxt;

  lcg32_step #(
    .LCG_MULT (LCG_MULT),
    .LCG_INC  (LCG_INC)
  ) u_step (
    .state_i (lcg_q),
    .state_o (lcg_nxt)
  );

  // Writes word k into its 32-bit lane; bits above OUT_W are simply dropped,
  // which truncates the last word.
  function automatic logic [OUT_W-1:0] put_word(input logic [OUT_W-1:0] v,
                                                input logic [WCNT_W-1:0] k,
                                                input logic [31:0]       w);
    logic [OUT_W-1:0] r;
    r = v;
    for (int b = 0; b < OUT_W; b++) begin
      if ((b / 32) == int'(k)) r[b] = w[b % 32];
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_vec_d = num_vec_q;
    lcg_d     = lcg_q;
    vec_d     = vec_q;
    vec_idx_d = vec_idx_q;
    word_d    = word_q;

    // Abort pre-empts every other update so vec keeps its value.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_d    = decode_mode(mode);
            num_vec_d = num_vec;
            lcg_d     = seed;
            vec_idx_d = '0;
            word_d    = '0;
            state_d   = (num_vec == '0) ? FINISH : FILL;
          end
        end
        FILL: begin
          case (mode_q)
            RANDOM: begin
              lcg_d = lcg_nxt;
              vec_d = put_word(vec_q, word_q, lcg_nxt);
            end
            COUNT:   vec_d = OUT_W'(vec_idx_q);
            default: ;
          endcase
          if (word_q == LAST_WORD) state_d = PRESENT;
          else                     word_d  = word_q + 1'b1;
        end
        PRESENT: begin
          if (vec_ready) begin
            if (vec_idx_q == (num_vec_q - CNT_W'(1))) begin
              state_d = FINISH;
            end else begin
              vec_idx_d = vec_idx_q + CNT_W'(1);
              word_d    = '0;
              state_d   = FILL;
            end
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= RANDOM;
      num_vec_q <= '0;
      lcg_q     <= '0;
      vec_q     <= '0;
      vec_idx_q <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_vec_q <= num_vec_d;
      lcg_q     <= lcg_d;
      vec_q     <= vec_d;
      vec_idx_q <= vec_idx_d;
      word_q    <= word_d;
    end
  end

  assign vec       = vec_q;
  assign vec_idx   = vec_idx_q;
  assign vec_valid = (state_q == PRESENT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

endmodule
